// File: rtl/tl_instruction_decode_pkg.sv
// Shared definitions for the MIPS ID stage: opcodes, ALU-op classes, control bundle.
package tl_instruction_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_LUI   = 3'b110
  } alu_op_e;

  // Control bundle carried through ID/EX; all-zero is a bubble.
  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    branch;
    logic    branch_ne;
    logic    jump;
    logic    invalid;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/tl_instruction_decode_register_file.sv
// 2-read / 1-write GPR file. Writes land on negedge so the following posedge
// already sees them; GPR0 is hardwired to zero.
module register_file #(
  parameter int LEN         = 32,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic [NB_REG_ADDR-1:0] i_waddr,
  input  logic [LEN-1:0]         i_wdata,
  input  logic [NB_REG_ADDR-1:0] i_raddr_a,
  input  logic [NB_REG_ADDR-1:0] i_raddr_b,
  output logic [LEN-1:0]         o_rdata_a,
  output logic [LEN-1:0]         o_rdata_b
);

  localparam int NREG = 1 << NB_REG_ADDR;

  logic [LEN-1:0] gpr_q [NREG];

  // Negedge write port with asynchronous clear of every register.
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      gpr_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : gpr_q[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : gpr_q[i_raddr_b];

endmodule

// File: rtl/tl_instruction_decode.sv
// MIPS ID stage: register read, control decode, immediate extension,
// branch/jump target generation, all registered into ID/EX.
module tl_instruction_decode
  import tl_instruction_decode_pkg::*;
#(
  parameter int LEN         = 32,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [LEN-1:0]         i_instruccion,
  input  logic [LEN-1:0]         i_adder,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_wb_reg_write,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [LEN-1:0]         i_wb_data,
  output logic [LEN-1:0]         o_adder,
  output logic [LEN-1:0]         o_rs_data,
  output logic [LEN-1:0]         o_rt_data,
  output logic [LEN-1:0]         o_imm_ext,
  output logic [NB_REG_ADDR-1:0] o_rs,
  output logic [NB_REG_ADDR-1:0] o_rt,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic [LEN-1:0]         o_branch_dir,
  output logic [LEN-1:0]         o_jump_dir,
  output logic                   o_reg_dst,
  output logic                   o_alu_src,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_mem_to_reg,
  output logic                   o_reg_write,
  output logic                   o_branch,
  output logic                   o_branch_ne,
  output logic                   o_jump,
  output logic [2:0]             o_alu_op,
  output logic                   o_invalid
);

  logic [5:0]             opcode;
  logic [15:0]            imm16;
  logic [NB_REG_ADDR-1:0] rs, rt, rd;
  logic [LEN-1:0]         rs_data, rt_data;
  logic [LEN-1:0]         imm_sext, imm_d, bdir_d, jdir_d;
  logic                   zero_ext;
  ctrl_t                  ctrl_d, ctrl_q;

  logic [LEN-1:0]         adder_q, rs_data_q, rt_data_q, imm_q, bdir_q, jdir_q;
  logic [NB_REG_ADDR-1:0] rs_q, rt_q, rd_q;

  assign opcode = i_instruccion[31:26];
  assign rs     = i_instruccion[25:21];
  assign rt     = i_instruccion[20:16];
  assign rd     = i_instruccion[15:11];
  assign imm16  = i_instruccion[15:0];

  register_file #(.LEN(LEN), .NB_REG_ADDR(NB_REG_ADDR)) u_regfile (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (i_wb_reg_write),
    .i_waddr   (i_wb_addr),
    .i_wdata   (i_wb_data),
    .i_raddr_a (rs),
    .i_raddr_b (rt),
    .o_rdata_a (rs_data),
    .o_rdata_b (rt_data)
  );

  // Opcode decode; don't-care entries resolve to 0, unknown opcodes flag invalid.
  always_comb begin
    ctrl_d   = CTRL_NONE;
    zero_ext = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_RTYPE;
      end
      OP_LW: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_d.branch_ne = 1'b1;
        ctrl_d.alu_op    = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_ANDI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_AND;
        zero_ext         = 1'b1;
      end
      OP_ORI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_OR;
        zero_ext         = 1'b1;
      end
      OP_SLTI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_SLT;
      end
      OP_LUI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_LUI;
        zero_ext         = 1'b1;
      end
      OP_J: begin
        ctrl_d.jump = 1'b1;
      end
      default: begin
        ctrl_d.invalid = 1'b1;
      end
    endcase
  end

  // Branch target is always sign-extended, independent of the ALU immediate mode.
  assign imm_sext = {{(LEN-16){imm16[15]}}, imm16};
  assign imm_d    = zero_ext ? {{(LEN-16){1'b0}}, imm16} : imm_sext;
  assign bdir_d   = i_adder + imm_sext;
  assign jdir_d   = {i_adder[LEN-1:26], i_instruccion[25:0]};

  // ID/EX register; stall or flush turns the control half into a bubble.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ctrl_q    <= CTRL_NONE;
      adder_q   <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      bdir_q    <= '0;
      jdir_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ctrl_q    <= (i_stall || i_flush) ? CTRL_NONE : ctrl_d;
      adder_q   <= i_adder;
      rs_data_q <= rs_data;
      rt_data_q <= rt_data;
      imm_q     <= imm_d;
      bdir_q    <= bdir_d;
      jdir_q    <= jdir_d;
      rs_q      <= rs;
      rt_q      <= rt;
      rd_q      <= rd;
    end
  end

  assign o_adder      = adder_q;
  assign o_rs_data    = rs_data_q;
  assign o_rt_data    = rt_data_q;
  assign o_imm_ext    = imm_q;
  assign o_rs         = rs_q;
  assign o_rt         = rt_q;
  assign o_rd         = rd_q;
  assign o_branch_dir = bdir_q;
  assign o_jump_dir   = jdir_q;
  assign o_reg_dst    = ctrl_q.reg_dst;
  assign o_alu_src    = ctrl_q.alu_src;
  assign o_mem_read   = ctrl_q.mem_read;
  assign o_mem_write  = ctrl_q.mem_write;
  assign o_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_reg_write  = ctrl_q.reg_write;
  assign o_branch     = ctrl_q.branch;
  assign o_branch_ne  = ctrl_q.branch_ne;
  assign o_jump       = ctrl_q.jump;
  assign o_alu_op     = ctrl_q.alu_op;
  assign o_invalid    = ctrl_q.invalid;

endmodule

// File: tb/tb_tl_instruction_decode.sv
// Bench for the ID stage: vector table plus reset corner sequences, scoreboard-checked.
module tb_tl_instruction_decode;

  logic        clk, rst;
  logic [31:0] instr, adder, wb_data;
  logic        stall, flush, wb_we;
  logic [4:0]  wb_addr;

  logic [31:0] o_adder, o_rs_data, o_rt_data, o_imm_ext, o_branch_dir, o_jump_dir;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg;
  logic        o_reg_write, o_branch, o_branch_ne, o_jump, o_invalid;
  logic [2:0]  o_alu_op;

  int n_cmp = 0;
  int n_bad = 0;

  tl_instruction_decode dut (
    .i_clk(clk), .i_rst(rst), .i_instruccion(instr), .i_adder(adder),
    .i_stall(stall), .i_flush(flush), .i_wb_reg_write(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_adder(o_adder), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm_ext(o_imm_ext), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_branch_dir(o_branch_dir), .o_jump_dir(o_jump_dir),
    .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
    .o_reg_write(o_reg_write), .o_branch(o_branch), .o_branch_ne(o_branch_ne),
    .o_jump(o_jump), .o_alu_op(o_alu_op), .o_invalid(o_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, branch_ne, jump, invalid}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] adder;
    logic        stall;
    logic        flush;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  ctrl;
    logic [2:0]  aluop;
  } vec_t;

  typedef struct {
    logic [31:0] adder, rs_data, rt_data, imm, bdir, jdir;
    logic [4:0]  rs, rt, rd;
    logic [9:0]  ctrl;
    logic [2:0]  aluop;
  } exp_t;

  localparam int NV = 22;
  vec_t        vt [NV];
  exp_t        sb [$];
  logic [31:0] shadow [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] act_ctrl();
    return {o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg,
            o_reg_write, o_branch, o_branch_ne, o_jump, o_invalid};
  endfunction

  // Drive one decode cycle and push what the ID/EX register must hold after the next posedge.
  task automatic drive(input vec_t v);
    exp_t       e;
    logic [5:0] op;
    instr   = v.instr;  adder = v.adder;
    stall   = v.stall;  flush = v.flush;
    wb_we   = v.we;     wb_addr = v.waddr; wb_data = v.wdata;
    if (v.we && v.waddr != 5'd0) shadow[v.waddr] = v.wdata;
    op        = v.instr[31:26];
    e.adder   = v.adder;
    e.rs      = v.instr[25:21];
    e.rt      = v.instr[20:16];
    e.rd      = v.instr[15:11];
    e.rs_data = shadow[e.rs];
    e.rt_data = shadow[e.rt];
    if (op == 6'b001100 || op == 6'b001101 || op == 6'b001111)
      e.imm = {16'h0000, v.instr[15:0]};
    else
      e.imm = {{16{v.instr[15]}}, v.instr[15:0]};
    e.bdir  = v.adder + {{16{v.instr[15]}}, v.instr[15:0]};
    e.jdir  = {v.adder[31:26], v.instr[25:0]};
    e.ctrl  = v.ctrl;
    e.aluop = v.aluop;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard: empty, expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " adder"},   o_adder,         e.adder);
    chk({tag, " rs_data"}, o_rs_data,       e.rs_data);
    chk({tag, " rt_data"}, o_rt_data,       e.rt_data);
    chk({tag, " imm"},     o_imm_ext,       e.imm);
    chk({tag, " bdir"},    o_branch_dir,    e.bdir);
    chk({tag, " jdir"},    o_jump_dir,      e.jdir);
    chk({tag, " rs"},      {27'd0, o_rs},   {27'd0, e.rs});
    chk({tag, " rt"},      {27'd0, o_rt},   {27'd0, e.rt});
    chk({tag, " rd"},      {27'd0, o_rd},   {27'd0, e.rd});
    chk({tag, " ctrl"},    {22'd0, act_ctrl()}, {22'd0, e.ctrl});
    chk({tag, " alu_op"},  {29'd0, o_alu_op},   {29'd0, e.aluop});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " adder"},   o_adder,      32'h0);
    chk({tag, " rs_data"}, o_rs_data,    32'h0);
    chk({tag, " rt_data"}, o_rt_data,    32'h0);
    chk({tag, " imm"},     o_imm_ext,    32'h0);
    chk({tag, " bdir"},    o_branch_dir, 32'h0);
    chk({tag, " jdir"},    o_jump_dir,   32'h0);
    chk({tag, " regidx"},  {17'd0, o_rs, o_rt, o_rd}, 32'h0);
    chk({tag, " ctrl"},    {22'd0, act_ctrl()}, 32'h0);
    chk({tag, " alu_op"},  {29'd0, o_alu_op}, 32'h0);
  endtask

  initial begin
    vec_t v;
    //          instr         adder         st    fl    we    wa     wdata         ctrl           aluop
    vt[0]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b1, 5'd5,  32'h12345678, 10'b1000010000, 3'b010};
    vt[1]  = '{32'h00000000, 32'h00000002, 1'b0, 1'b0, 1'b1, 5'd6,  32'h00000010, 10'b1000010000, 3'b010};
    vt[2]  = '{32'h00A61820, 32'h00000003, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b1000010000, 3'b010};
    vt[3]  = '{32'h8C22FFFC, 32'h00000004, 1'b0, 1'b0, 1'b1, 5'd1,  32'h00000100, 10'b0110110000, 3'b000};
    vt[4]  = '{32'h3421F000, 32'h00000005, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0100010000, 3'b100};
    vt[5]  = '{32'h10220003, 32'h00000010, 1'b0, 1'b0, 1'b1, 5'd2,  32'hDEADBEEF, 10'b0000001000, 3'b001};
    vt[6]  = '{32'h1022FFFE, 32'h00000010, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0000001000, 3'b001};
    vt[7]  = '{32'h14220001, 32'h00000020, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0000000100, 3'b001};
    vt[8]  = '{32'h08000040, 32'h00000010, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0000000010, 3'b000};
    vt[9]  = '{32'h2021FFFF, 32'h00000030, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0100010000, 3'b000};
    vt[10] = '{32'h3021FFFF, 32'h00000031, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0100010000, 3'b011};
    vt[11] = '{32'h2821FFFF, 32'h00000032, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0100010000, 3'b101};
    vt[12] = '{32'h3C011234, 32'h00000033, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0100010000, 3'b110};
    vt[13] = '{32'hAC22FFFC, 32'h00000034, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0101000000, 3'b000};
    vt[14] = '{32'h00001020, 32'h00000035, 1'b0, 1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 10'b1000010000, 3'b010};
    vt[15] = '{32'h00E04020, 32'h00000036, 1'b0, 1'b0, 1'b1, 5'd7,  32'hA5A5A5A5, 10'b1000010000, 3'b010};
    vt[16] = '{32'h8CE2FFFC, 32'h00000037, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0000000000, 3'b000};
    vt[17] = '{32'h8CE2FFFC, 32'h00000038, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        10'b0000000000, 3'b000};
    vt[18] = '{32'h8CE2FFFC, 32'h00000039, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        10'b0000000000, 3'b000};
    vt[19] = '{32'hFC000000, 32'h0000003A, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0000000001, 3'b000};
    vt[20] = '{32'h10220001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0000001000, 3'b001};
    vt[21] = '{32'h08000040, 32'hFC000010, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        10'b0000000010, 3'b000};

    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    rst = 1'b0; instr = '0; adder = '0; stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    #12;
    check_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i]);
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i));
    end

    // Absolute spot checks on spec reference values (independent of the model).
    // vt[21] is the last applied: jump_dir wraps into adder's top bits.
    chk("jdir_upper", o_jump_dir, 32'hFC000040);

    // Load lw reading r5 so outputs are nonzero, then pull reset mid-cycle.
    v = '{32'h8CA2FFFC, 32'h00000044, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 10'b0110110000, 3'b000};
    drive(v);
    @(posedge clk); #1;
    check_out("pre_rst");
    chk("pre_rst r5", o_rs_data, 32'h12345678);
    #3;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    #2;
    rst = 1'b1;

    // After reset, r5 and r6 must read back 0.
    v = '{32'h00A61820, 32'h00000050, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 10'b1000010000, 3'b010};
    drive(v);
    @(posedge clk); #1;
    check_out("post_rst");
    chk("post_rst r5", o_rs_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
